// File: rtl/data_mem_responder.sv
// data_mem_responder: word-array data memory that answers RV32I load/store requests over a valid/ready
// request channel and a valid/ready response channel, after WAIT_CYCLES wait states.
// Ports: clk, reset_n (async active-low); req_valid/req_ready/req_we/req_addr/req_func3/req_wdata request;
// rsp_valid/rsp_ready/rsp_rdata/rsp_err response.
// Macro DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses raise rsp_err instead of being force-aligned.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic we_q;
  logic [31:0] addr_q, wdata_q;
  logic [2:0] func3_q;
  logic [31:0] mem [DEPTH_WORDS];
  logic we_c;
  logic [31:0] addr_c, wdata_c;
  logic [2:0] func3_c;
  logic bad_f3, oor, mis, err, enter_resp, wr_en;
  logic [1:0] off;
  logic [3:0] be;
  logic [31:0] word, sh, rdata, wdata_al;
  logic [AW-1:0] idx;
  // With WAIT_CYCLES=0 RESP is entered on the acceptance edge, so the live request is decoded in IDLE.
  assign we_c    = state == IDLE ? req_we : we_q;
  assign addr_c  = state == IDLE ? req_addr : addr_q;
  assign func3_c = state == IDLE ? req_func3 : func3_q;
  assign wdata_c = state == IDLE ? req_wdata : wdata_q;
  assign bad_f3 = func3_c == 3'b011 || func3_c[2:1] == 2'b11 || (we_c && func3_c[2]);
  assign oor    = addr_c[31:2] >= 30'(DEPTH_WORDS);
`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis = (func3_c[1:0] == 2'b01 && addr_c[0]) || (func3_c[1:0] == 2'b10 && addr_c[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign err = bad_f3 | oor | mis;
  // Byte lane offset with the sub-size address bits forced to zero; trapping builds error out before using it.
  assign off = func3_c[1:0] == 2'b00 ? addr_c[1:0] : func3_c[1:0] == 2'b01 ? {addr_c[1], 1'b0} : 2'b00;
  assign idx      = addr_c[AW+1:2];
  assign word     = mem[idx];
  assign sh       = word >> {off, 3'b000};
  assign rdata    = func3_c[1:0] == 2'b00 ? {{24{~func3_c[2] & sh[7]}}, sh[7:0]} :
                    func3_c[1:0] == 2'b01 ? {{16{~func3_c[2] & sh[15]}}, sh[15:0]} : word;
  assign be       = func3_c[1:0] == 2'b00 ? 4'b0001 << off : func3_c[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
  assign wdata_al = wdata_c << {off, 3'b000};
  assign enter_resp = state != RESP && state_nx == RESP;
  assign wr_en      = enter_resp && we_c && !err;
  assign req_ready  = state == IDLE;
  assign rsp_valid  = state == RESP;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: if (req_valid) begin
        state_nx = WAIT_CYCLES > 0 ? WAIT : RESP;
        cnt_nx   = WAIT_CYCLES > 0 ? 4'(WAIT_CYCLES - 1) : cnt;
      end
      WAIT: begin
        state_nx = cnt == 4'd0 ? RESP : WAIT;
        cnt_nx   = cnt == 4'd0 ? cnt : cnt - 4'd1;
      end
      RESP: state_nx = rsp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      func3_q   <= '0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (req_valid && req_ready) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        func3_q <= req_func3;
        wdata_q <= req_wdata;
      end
      if (enter_resp) begin
        rsp_rdata <= (err || we_c) ? '0 : rdata;
        rsp_err   <= err;
      end
    end
  end
  // Storage is deliberately not reset; a store only commits on the edge that enters RESP.
  always_ff @(posedge clk)
    if (wr_en)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wdata_al[8*b +: 8];
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks of data_mem_responder against a byte-array model.
module tb_data_mem_responder;
  localparam int DEPTH = 256;
  localparam int WAITC = 1;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0] req_func3 = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0] mb [4*DEPTH];
  int n_chk = 0, n_fail = 0;
  logic [31:0] got;
  logic gerr;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_func3(req_func3), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Little-endian byte memory; sizes are 1/2/4 bytes, misaligned addresses round down unless trapping.
  function automatic void model(input logic we, input logic [31:0] a, input logic [2:0] f3,
                                input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int n;
    logic [31:0] base, v;
    n   = f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
    err = f3 == 3'd3 || f3 >= 3'd6 || (we && f3 >= 3'd4) || (a >> 2) >= DEPTH;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (a % n != 0) err = 1'b1;
`endif
    base = a - (a % n);
    rd   = '0;
    if (!err) begin
      if (we) begin
        for (int i = 0; i < n; i++) mb[base + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[base + i]) << (8 * i));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        rd = v;
      end
    end
  endfunction

  task automatic junk();
    req_valid = 1'($urandom);
    req_we    = 1'($urandom);
    req_addr  = $urandom;
    req_func3 = 3'($urandom);
    req_wdata = $urandom;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
  task automatic xact(input logic we, input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd,
                      input int hold, output logic [31:0] r, output logic e);
    logic [31:0] erd;
    logic eerr;
    int lat;
    model(we, a, f3, wd, erd, eerr);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_func3 = f3;
    req_wdata = wd;
    @(negedge clk);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      junk();
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(WAITC + 1));
    chk("rsp_rdata", rsp_rdata, erd);
    chk("rsp_err", 32'(rsp_err), 32'(eerr));
    chk("req_ready_resp", 32'(req_ready), 32'd0);
    r = rsp_rdata;
    e = rsp_err;
    repeat (hold) begin
      junk();
      req_valid = 1'b1;
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_rdata", rsp_rdata, r);
      chk("hold_err", 32'(rsp_err), 32'(e));
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    junk();
    req_valid = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_valid", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) xact(1'b1, 32'(4 * i), 3'b010, $urandom, 0, got, gerr);
    xact(1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF, 0, got, gerr);
    xact(1'b0, 32'h10, 3'b010, 32'h0, 0, got, gerr);
    chk("lw10", got, 32'hDEAD_BEEF);
    xact(1'b0, 32'h13, 3'b000, 32'h0, 0, got, gerr);
    chk("lb13", got, 32'hFFFF_FFDE);
    xact(1'b0, 32'h13, 3'b100, 32'h0, 0, got, gerr);
    chk("lbu13", got, 32'h0000_00DE);
    xact(1'b0, 32'h12, 3'b001, 32'h0, 0, got, gerr);
    chk("lh12", got, 32'hFFFF_DEAD);
    xact(1'b0, 32'h10, 3'b101, 32'h0, 0, got, gerr);
    chk("lhu10", got, 32'h0000_BEEF);
    xact(1'b1, 32'h11, 3'b000, 32'h55, 0, got, gerr);
    xact(1'b0, 32'h10, 3'b010, 32'h0, 5, got, gerr);
    chk("sb_merge", got, 32'hDEAD_55EF);
    xact(1'b0, 32'h400, 3'b010, 32'h0, 0, got, gerr);
    chk("oor_err", 32'(gerr), 32'd1);
    chk("oor_rdata", got, 32'd0);
    xact(1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF, 0, got, gerr);
    xact(1'b0, 32'h12, 3'b010, 32'h0, 0, got, gerr);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("mis_err", 32'(gerr), 32'd1);
    chk("mis_rdata", got, 32'd0);
`else
    chk("mis_err", 32'(gerr), 32'd0);
    chk("mis_rdata", got, 32'hDEAD_BEEF);
`endif
    xact(1'b1, 32'h20, 3'b010, 32'hCAFE_F00D, 0, got, gerr);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_func3 = 3'b010;
    req_wdata = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b0;
    chk("mid_wait_ready", 32'(req_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_valid", 32'(rsp_valid), 32'd0);
    chk("abort_rdata", rsp_rdata, 32'd0);
    chk("abort_err", 32'(rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    xact(1'b0, 32'h20, 3'b010, 32'h0, 0, got, gerr);
    chk("abort_kept", got, 32'hCAFE_F00D);
    for (int i = 0; i < 300; i++)
      xact(1'($urandom), 32'($urandom_range(0, 4 * DEPTH + 31)), 3'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 3), got, gerr);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
